led_panel_bcm: RTL and testbench
================================

LED_PANEL_BCM -- requirements
Module: led_panel_bcm

Interface
REQ-001 Parameter COLS, default 64, columns shifted per row (2..256).
REQ-002 Parameter ROW_BITS, default 6, width of row counter and rowmax_in.
REQ-003 Parameter PLANES, default 4, intensity bits per colour (1..8).
REQ-004 Parameter PAUSE_BASE, default 256, display cycles for bit-plane 0 (>=1).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 rowmax_in  in  ROW_BITS  index of last row before wrap.
REQ-008 mode_in  in  2  test-pattern select.
REQ-009 red_out/green_out/blue_out  out  1 each  serial colour data.
REQ-010 sclk_out, latch_out (active-low), blank_out (active-high)  out  1 each  column shift controls.
REQ-011 aclk_out, arst_out  out  1 each  row-driver clock and reset.
REQ-012 frame_out  out  1  one-cycle pulse at frame wrap.

Function
REQ-013 States: FIRSTCOL, CLK_LO, CLK_HI, LATCH, UNBLANK, PAUSE, NEXTROW; all outputs registered.
REQ-014 FIRSTCOL: blank=1, latch=1, sclk=0, aclk=0, arst=0, frame=0, col=0; register mode_in for this plane; next CLK_LO.
REQ-015 CLK_LO: sclk=0, drive lower-half pixel bit; next CLK_HI.
REQ-016 CLK_HI: sclk=1, drive upper-half pixel bit, col+1; next LATCH if col==COLS-1, else CLK_LO; exactly COLS sclk rising edges per plane.
REQ-017 LATCH: sclk=0, latch=0 one cycle; UNBLANK: latch=1, blank=0, load pause counter.
REQ-018 PAUSE lasts exactly PAUSE_BASE<<p cycles (p = current plane); on exit blank=1; blank_out low exactly that many cycles.
REQ-019 PAUSE exit: p<PLANES-1 -> p+1, FIRSTCOL; else p=0, NEXTROW.
REQ-020 NEXTROW: if row>=rowmax_in then row=0, arst=1, frame=1; else row+1, aclk=1; next FIRSTCOL (pulses one cycle).
REQ-021 Pixel intensity per colour is PLANES bits; output bit = intensity[p]; index sources zero-extended/truncated to PLANES bits; half=0 upper, 1 lower.
REQ-022 mode 0: all colours all-ones.
REQ-023 mode 1: all colours all-ones if col[0]^row[0]^half, else zero.
REQ-024 mode 2: red=col, green=row, blue all-ones when half=1 else zero.
REQ-025 mode 3: {r,g,b} on/off = bits [2:0] of (col/8) mod 8, on=all-ones.
REQ-026 Cycles per row = sum over p of (3+2*COLS+(PAUSE_BASE<<p)) + 1.
REQ-027 mode_in changes take effect only at next FIRSTCOL; rowmax_in sampled in NEXTROW only.

Reset
REQ-028 reset=0 at any edge, any state: next state FIRSTCOL, row=0, p=0, col=0, rgb=0, sclk=0, latch=1, blank=1, arst=1, aclk=0, frame=0.
REQ-029 Reset mid-PAUSE or mid-shift aborts immediately; no latch pulse completes.

Configuration
REQ-030 Macro LED_PANEL_BCM_EN defined: PLANES bit-planes with binary-weighted pause per REQ-018/019.
REQ-031 Macro undefined: single plane only, pause PAUSE_BASE cycles, output bit = intensity MSB; PLANES still sets pattern width.

Verification (bench: COLS=4, PLANES=2, PAUSE_BASE=4, ROW_BITS=6, LED_PANEL_BCM_EN defined unless stated)
REQ-032 reset=0 for 3 cycles -> blank=1, latch=1, sclk=0, arst=1, aclk=0, rgb=0, frame=0.
REQ-033 Release, mode 0 -> 4 sclk rises per plane, blank low 4 then 8 cycles, row period 35 cycles, every sampled bit 1.
REQ-034 rowmax_in=2 -> aclk pulses after rows 0,1; after row 2 arst and frame pulse once; rows repeat 0,1,2.
REQ-035 mode 2, row 0 -> red bits at sclk rise, plane0: 0,1,0,1; plane1: 0,0,1,1; blue lower=1, upper=0.
REQ-036 reset=0 during plane-1 PAUSE -> next cycle blank=1, arst=1; restarts row 0 plane 0 with no extra latch.
REQ-037 Macro undefined, mode 2 -> one plane per row, blank low 4 cycles, red = col[1]: 0,0,1,1; row period 16 cycles.

Source files
------------

// File: rtl/led_panel_bcm.sv
// rtl/led_panel_bcm.sv - LED matrix panel scanner with binary-coded-modulation bit-planes
// Macro LED_PANEL_BCM_EN enables PLANES weighted bit-planes; undefined scans a single MSB plane.
module led_panel_bcm #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 6,
  parameter int PLANES     = 4,
  parameter int PAUSE_BASE = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROW_BITS-1:0] rowmax_in,
  input  logic [1:0]          mode_in,
  output logic                red_out,
  output logic                green_out,
  output logic                blue_out,
  output logic                sclk_out,
  output logic                latch_out,
  output logic                blank_out,
  output logic                aclk_out,
  output logic                arst_out,
  output logic                frame_out
);

  localparam int CW = $clog2(COLS + 1);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  typedef enum logic [2:0] {
    S_FIRSTCOL, S_CLK_LO, S_CLK_HI, S_LATCH, S_UNBLANK, S_PAUSE, S_NEXTROW
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q;
  logic [ROW_BITS-1:0] row_q;
  logic [PW-1:0]       p_q;
  logic [1:0]          mode_q;
  logic [31:0]         cnt_q;
  logic                last_col, pause_done, last_plane;

  logic [2:0] rgb_q, rgb_d;
  logic       sclk_d, latch_d, blank_d, aclk_d, arst_d, frame_d;

  logic              half;
  logic [PLANES-1:0] ones, r_int, g_int, b_int;
  logic [2:0]        sel;
  logic [PW-1:0]     bit_idx;
  logic [2:0]        pix;

  assign last_col   = (col_q == CW'(COLS - 1));
  assign pause_done = (cnt_q == 32'd0);

`ifdef LED_PANEL_BCM_EN
  assign last_plane = (p_q == PW'(PLANES - 1));
  assign bit_idx    = p_q;
`else
  assign last_plane = 1'b1;
  assign bit_idx    = PW'(PLANES - 1);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FIRSTCOL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FIRSTCOL: state_d = S_CLK_LO;
      S_CLK_LO:   state_d = S_CLK_HI;
      S_CLK_HI:   state_d = last_col ? S_LATCH : S_CLK_LO;
      S_LATCH:    state_d = S_UNBLANK;
      S_UNBLANK:  state_d = S_PAUSE;
      S_PAUSE:    if (pause_done) state_d = last_plane ? S_NEXTROW : S_FIRSTCOL;
      S_NEXTROW:  state_d = S_FIRSTCOL;
      default:    state_d = S_FIRSTCOL;
    endcase
  end

  // Test-pattern intensities; the lower half is shifted while sclk is low.
  always_comb begin
    half  = (state_q == S_CLK_LO);
    ones  = '1;
    sel   = 3'(col_q >> 3);
    r_int = '0;
    g_int = '0;
    b_int = '0;
    case (mode_q)
      2'd0: begin
        r_int = ones; g_int = ones; b_int = ones;
      end
      2'd1: begin
        if (col_q[0] ^ row_q[0] ^ half) begin
          r_int = ones; g_int = ones; b_int = ones;
        end
      end
      2'd2: begin
        r_int = PLANES'(col_q);
        g_int = PLANES'(row_q);
        b_int = half ? ones : '0;
      end
      default: begin
        r_int = sel[2] ? ones : '0;
        g_int = sel[1] ? ones : '0;
        b_int = sel[0] ? ones : '0;
      end
    endcase
    pix = {r_int[bit_idx], g_int[bit_idx], b_int[bit_idx]};
  end

  // Outputs register the action of the current state, so they lag it by one cycle.
  always_comb begin
    rgb_d   = rgb_q;
    sclk_d  = sclk_out;
    latch_d = latch_out;
    blank_d = blank_out;
    aclk_d  = aclk_out;
    arst_d  = arst_out;
    frame_d = frame_out;
    case (state_q)
      S_FIRSTCOL: begin
        blank_d = 1'b1; latch_d = 1'b1; sclk_d = 1'b0;
        aclk_d  = 1'b0; arst_d  = 1'b0; frame_d = 1'b0;
      end
      S_CLK_LO: begin
        sclk_d = 1'b0; rgb_d = pix;
      end
      S_CLK_HI: begin
        sclk_d = 1'b1; rgb_d = pix;
      end
      S_LATCH: begin
        sclk_d = 1'b0; latch_d = 1'b0;
      end
      S_UNBLANK: begin
        latch_d = 1'b1; blank_d = 1'b0;
      end
      S_PAUSE: begin
        if (pause_done) blank_d = 1'b1;
      end
      S_NEXTROW: begin
        if (row_q >= rowmax_in) begin
          arst_d = 1'b1; frame_d = 1'b1;
        end else begin
          aclk_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q     <= 3'b000;
      sclk_out  <= 1'b0;
      latch_out <= 1'b1;
      blank_out <= 1'b1;
      aclk_out  <= 1'b0;
      arst_out  <= 1'b1;
      frame_out <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      sclk_out  <= sclk_d;
      latch_out <= latch_d;
      blank_out <= blank_d;
      aclk_out  <= aclk_d;
      arst_out  <= arst_d;
      frame_out <= frame_d;
    end
  end

  assign red_out   = rgb_q[2];
  assign green_out = rgb_q[1];
  assign blue_out  = rgb_q[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      p_q    <= '0;
      mode_q <= 2'd0;
      cnt_q  <= 32'd0;
    end else begin
      case (state_q)
        S_FIRSTCOL: begin
          col_q  <= '0;
          mode_q <= mode_in;
        end
        S_CLK_HI:  col_q <= col_q + CW'(1);
        S_UNBLANK: cnt_q <= (32'(PAUSE_BASE) << p_q) - 32'd1;
        S_PAUSE: begin
          if (!pause_done)      cnt_q <= cnt_q - 32'd1;
          else if (!last_plane) p_q   <= p_q + PW'(1);
          else                  p_q   <= '0;
        end
        S_NEXTROW: row_q <= (row_q >= rowmax_in) ? '0 : row_q + ROW_BITS'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel_bcm.sv
// tb/tb_led_panel_bcm.sv - randomized bench for led_panel_bcm against an event-level panel model
module tb_led_panel_bcm;
  localparam int COLS = 4, PLANES = 2, PAUSE_BASE = 4, ROW_BITS = 6;
`ifdef LED_PANEL_BCM_EN
  localparam int NP = PLANES;
  localparam bit BCM = 1'b1;
`else
  localparam int NP = 1;
  localparam bit BCM = 1'b0;
`endif

  logic clk, reset;
  logic [ROW_BITS-1:0] rowmax_in;
  logic [1:0] mode_in;
  logic red_out, green_out, blue_out, sclk_out, latch_out, blank_out, aclk_out, arst_out, frame_out;

  led_panel_bcm #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .PAUSE_BASE(PAUSE_BASE)) dut (
    .clk(clk), .reset(reset), .rowmax_in(rowmax_in), .mode_in(mode_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .sclk_out(sclk_out), .latch_out(latch_out), .blank_out(blank_out),
    .aclk_out(aclk_out), .arst_out(arst_out), .frame_out(frame_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event monitor: turns the pin waveform into shifted pixels, latches, blank runs and row pulses.
  bit         mon_en = 1'b0;
  int         cyc, blank_run, frame_err;
  logic [2:0] prev_rgb;
  logic       prev_sclk;
  logic [5:0] shift_q[$];
  int         blank_q[$];
  int         latch_q[$];
  int         pulse_cyc_q[$];
  int         pulse_kind_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (sclk_out && !prev_sclk) shift_q.push_back({prev_rgb, red_out, green_out, blue_out});
      if (!latch_out) latch_q.push_back(shift_q.size());
      if (!blank_out) blank_run++;
      else if (blank_run > 0) begin
        blank_q.push_back(blank_run);
        blank_run = 0;
      end
      if (aclk_out || arst_out) begin
        pulse_cyc_q.push_back(cyc);
        pulse_kind_q.push_back(arst_out ? (aclk_out ? 3 : 2) : 1);
        if (frame_out !== arst_out) frame_err++;
      end else if (frame_out) frame_err++;
      prev_rgb  = {red_out, green_out, blue_out};
      prev_sclk = sclk_out;
    end
  end

  function automatic int pause_len(int p);
    return BCM ? (PAUSE_BASE << p) : PAUSE_BASE;
  endfunction

  function automatic int row_period();
    int s = 1;
    for (int p = 0; p < NP; p++) s += 3 + 2 * COLS + pause_len(p);
    return s;
  endfunction

  function automatic logic [2:0] exp_bits(int mode, int col, int row, int half, int p);
    int full, r, g, b, s, bi;
    full = (1 << PLANES) - 1;
    case (mode)
      0: begin r = full; g = full; b = full; end
      1: begin
        r = (((col ^ row ^ half) & 1) != 0) ? full : 0;
        g = r; b = r;
      end
      2: begin
        r = col % (1 << PLANES);
        g = row % (1 << PLANES);
        b = (half != 0) ? full : 0;
      end
      default: begin
        s = (col / 8) % 8;
        r = ((s & 4) != 0) ? full : 0;
        g = ((s & 2) != 0) ? full : 0;
        b = ((s & 1) != 0) ? full : 0;
      end
    endcase
    bi = BCM ? p : PLANES - 1;
    return {1'((r >> bi) & 1), 1'((g >> bi) & 1), 1'((b >> bi) & 1)};
  endfunction

  task automatic test_reset();
    logic [8:0] got;
    reset = 1'b0;
    mode_in = 2'($urandom);
    rowmax_in = ROW_BITS'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {blank_out, latch_out, sclk_out, arst_out, aclk_out, red_out, green_out, blue_out, frame_out};
      n_cmp++;
      if (got !== 9'b1_1_0_1_0_000_0) begin
        n_bad++;
        $display("FAIL reset_state cycle %0d: got %b want 110100000", i, got);
      end
    end
  endtask

  // Reset, release, run whole rows and compare every observed event with the model.
  task automatic test_pattern(int mode, int rowmax, int nrows);
    int per, k, p, c, row, nexp;
    logic [5:0] want;
    per = row_period();
    mode_in = 2'(mode);
    rowmax_in = ROW_BITS'(rowmax);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    shift_q.delete(); blank_q.delete(); latch_q.delete();
    pulse_cyc_q.delete(); pulse_kind_q.delete();
    cyc = 0; blank_run = 0; frame_err = 0; prev_rgb = 3'b000; prev_sclk = 1'b0;
    mon_en = 1'b1;
    repeat (nrows * per) @(negedge clk);
    #1;
    mon_en = 1'b0;

    nexp = nrows * NP * COLS;
    n_cmp++;
    if (shift_q.size() != nexp) begin
      n_bad++;
      $display("FAIL sclk_rises mode %0d: got %0d want %0d", mode, shift_q.size(), nexp);
    end
    for (int i = 0; i < nexp && i < shift_q.size(); i++) begin
      k = i / (NP * COLS);
      p = (i / COLS) % NP;
      c = i % COLS;
      row = k % (rowmax + 1);
      want = {exp_bits(mode, c, row, 1, p), exp_bits(mode, c, row, 0, p)};
      n_cmp++;
      if (shift_q[i] !== want) begin
        n_bad++;
        $display("FAIL pixel mode %0d row %0d plane %0d col %0d: got lo/hi %b want %b", mode, row, p, c, shift_q[i], want);
      end
    end

    n_cmp++;
    if (blank_q.size() != nrows * NP || latch_q.size() != nrows * NP) begin
      n_bad++;
      $display("FAIL plane_count: got blank %0d latch %0d want %0d", blank_q.size(), latch_q.size(), nrows * NP);
    end
    for (int j = 0; j < nrows * NP && j < blank_q.size(); j++) begin
      n_cmp++;
      if (blank_q[j] != pause_len(j % NP)) begin
        n_bad++;
        $display("FAIL blank_low plane %0d: got %0d want %0d", j % NP, blank_q[j], pause_len(j % NP));
      end
    end
    for (int j = 0; j < nrows * NP && j < latch_q.size(); j++) begin
      n_cmp++;
      if (latch_q[j] != (j + 1) * COLS) begin
        n_bad++;
        $display("FAIL latch_position %0d: got %0d shifts want %0d", j, latch_q[j], (j + 1) * COLS);
      end
    end

    n_cmp++;
    if (pulse_cyc_q.size() != nrows) begin
      n_bad++;
      $display("FAIL row_pulses: got %0d want %0d", pulse_cyc_q.size(), nrows);
    end
    for (int j = 0; j < nrows && j < pulse_cyc_q.size(); j++) begin
      n_cmp++;
      if (pulse_cyc_q[j] != (j + 1) * per || pulse_kind_q[j] != (((j % (rowmax + 1)) == rowmax) ? 2 : 1)) begin
        n_bad++;
        $display("FAIL row_pulse %0d: got cycle %0d kind %0d want cycle %0d kind %0d", j, pulse_cyc_q[j],
                 pulse_kind_q[j], (j + 1) * per, ((j % (rowmax + 1)) == rowmax) ? 2 : 1);
      end
    end
    n_cmp++;
    if (frame_err != 0) begin
      n_bad++;
      $display("FAIL frame_pulse: got %0d cycles where frame differs from arst want 0", frame_err);
    end
  endtask

  // Reset asserted in the last plane's pause (in_pause) or while sclk is high.
  task automatic test_reset_abort(bit in_pause);
    bit found = 1'b0;
    int nfall = 0;
    logic prev_b = 1'b1;
    logic [5:0] got;
    mode_in = 2'd0;
    rowmax_in = ROW_BITS'(3);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (in_pause) begin
        if (!blank_out && prev_b) begin
          nfall++;
          if (nfall == NP) found = 1'b1;
        end
        prev_b = blank_out;
      end else if (sclk_out && i > 4) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL abort_trigger pause=%0d: got no trigger want trigger within 300 cycles", in_pause);
    end
    if (in_pause) repeat ($urandom_range(0, pause_len(NP - 1) - 2)) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {blank_out, latch_out, sclk_out, arst_out, aclk_out, frame_out};
      n_cmp++;
      if (got !== 6'b110100) begin
        n_bad++;
        $display("FAIL abort_outputs pause=%0d cycle %0d: got %b want 110100", in_pause, i, got);
      end
    end
    test_pattern(0, int'($urandom_range(0, 2)), 2);
  endtask

  initial begin
    reset = 1'b0;
    mode_in = 2'd0;
    rowmax_in = '0;
    test_reset();
    test_pattern(0, int'($urandom_range(1, 4)), 3);
    test_pattern(0, 2, 4);
    test_pattern(2, int'($urandom_range(0, 3)), 3);
    test_pattern(1, int'($urandom_range(0, 3)), 3);
    test_pattern(3, int'($urandom_range(0, 3)), 2);
    for (int t = 0; t < 3; t++) test_pattern(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3);
    test_reset_abort(1'b1);
    test_reset_abort(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
